// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter BHT plus a direct-mapped tagged BTB, trained only by
// resolved branches. Define LEN5_BPU_GSHARE_EN to hash the BHT index with a global
// history register (gshare). Without it the BHT is indexed by the PC alone (bimodal).

package fetch_pkg;
   localparam int XLEN = 32;
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
      logic            taken;
      logic            mispredict;
   } resolution_t;
endpackage

module branch_predictor
   import fetch_pkg::*;
#(
   parameter int BHT_BITS = 8,
   parameter int BTB_BITS = 4,
   parameter int HLEN     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [XLEN-1:0]   curr_pc_i,
   output logic              pred_taken_o,
   output logic [XLEN-1:0]   pred_target_o,
   output logic              btb_hit_o,
   input  logic              res_valid_i,
   input  resolution_t       res_i,
   output logic [31:0]       mispred_cnt_o
);
   localparam int BHT_N = 1 << BHT_BITS;
   localparam int BTB_N = 1 << BTB_BITS;
   localparam int TAG_W = XLEN - BTB_BITS - 2;

   if (HLEN < 1 || HLEN > BHT_BITS) begin : g_bad_hlen
      $error("HLEN must lie in 1..BHT_BITS");
   end

   logic [1:0]          bht_q [BHT_N];
   logic [1:0]          bht_d [BHT_N];
   logic [BTB_N-1:0]    btb_valid_q, btb_valid_d;
   logic [TAG_W-1:0]    btb_tag_q [BTB_N];
   logic [TAG_W-1:0]    btb_tag_d [BTB_N];
   logic [XLEN-1:0]     btb_target_q [BTB_N];
   logic [XLEN-1:0]     btb_target_d [BTB_N];
   logic [31:0]         mispred_cnt_q, mispred_cnt_d;
   logic [BHT_BITS-1:0] lk_bht_idx, up_bht_idx;
   logic [BTB_BITS-1:0] lk_btb_idx, up_btb_idx;
   logic [1:0]          up_ctr;
   logic                unused_pc_lsbs;

   assign unused_pc_lsbs = ^res_i.pc[1:0];
   assign lk_btb_idx     = curr_pc_i[BTB_BITS+1:2];
   assign up_btb_idx     = res_i.pc[BTB_BITS+1:2];
   assign up_ctr         = bht_q[up_bht_idx];
   assign mispred_cnt_o  = mispred_cnt_q;

`ifdef LEN5_BPU_GSHARE_EN
   logic [HLEN-1:0] ghr_q, ghr_d;
   assign lk_bht_idx = curr_pc_i[BHT_BITS+1:2] ^ BHT_BITS'(ghr_q);
   assign up_bht_idx = res_i.pc[BHT_BITS+1:2] ^ BHT_BITS'(ghr_q);
`else
   assign lk_bht_idx = curr_pc_i[BHT_BITS+1:2];
   assign up_bht_idx = res_i.pc[BHT_BITS+1:2];
`endif

   // Lookup is purely combinational and sees pre-update table contents
   always_comb begin
      btb_hit_o     = btb_valid_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == curr_pc_i[XLEN-1:BTB_BITS+2]);
      pred_taken_o  = btb_hit_o && bht_q[lk_bht_idx][1];
      pred_target_o = pred_taken_o ? btb_target_q[lk_btb_idx] : curr_pc_i + XLEN'(4);
   end

   // Train counter, BTB, history and mispredict count from a resolution record
   always_comb begin
      bht_d         = bht_q;
      btb_valid_d   = btb_valid_q;
      btb_tag_d     = btb_tag_q;
      btb_target_d  = btb_target_q;
      mispred_cnt_d = mispred_cnt_q;
`ifdef LEN5_BPU_GSHARE_EN
      ghr_d         = ghr_q;
`endif
      if (res_valid_i) begin
         bht_d[up_bht_idx] = res_i.taken ? ((up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1)
                                         : ((up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1);
         if (res_i.taken) begin
            btb_valid_d[up_btb_idx]  = 1'b1;
            btb_tag_d[up_btb_idx]    = res_i.pc[XLEN-1:BTB_BITS+2];
            btb_target_d[up_btb_idx] = res_i.target;
         end
         mispred_cnt_d = res_i.mispredict ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
`ifdef LEN5_BPU_GSHARE_EN
         ghr_d = HLEN'({ghr_q, res_i.taken});
`endif
      end
   end

   // State that must return to known values on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
         btb_valid_q   <= '0;
         mispred_cnt_q <= '0;
`ifdef LEN5_BPU_GSHARE_EN
         ghr_q         <= '0;
`endif
      end else begin
         bht_q         <= bht_d;
         btb_valid_q   <= btb_valid_d;
         mispred_cnt_q <= mispred_cnt_d;
`ifdef LEN5_BPU_GSHARE_EN
         ghr_q         <= ghr_d;
`endif
      end
   end

   // BTB payload is qualified by the valid bits, so it carries no reset
   always_ff @(posedge clk_i) begin
      btb_tag_q    <= btb_tag_d;
      btb_target_q <= btb_target_d;
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: table-driven vectors with a scoreboard queue for branch_predictor
// (bimodal vectors by default, gshare sequence when LEN5_BPU_GSHARE_EN is defined).
module tb_branch_predictor;
   import fetch_pkg::*;

   typedef struct {
      logic        v;
      logic [31:0] pc, tgt;
      logic        t, m;
      logic [31:0] lk;
      logic        hit, tk;
      logic [31:0] etgt, cnt;
   } vec_t;

   typedef struct {
      int          id;
      logic        hit, tk;
      logic [31:0] tgt, cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        res_valid_i = 1'b0;
   logic [31:0] curr_pc_i = 32'h1000;
   resolution_t res_i = '0;
   logic        pred_taken_o, btb_hit_o;
   logic [31:0] pred_target_o, mispred_cnt_o;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   branch_predictor dut (
      .clk_i(clk), .rst_i(rst_i), .curr_pc_i(curr_pc_i),
      .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o), .btb_hit_o(btb_hit_o),
      .res_valid_i(res_valid_i), .res_i(res_i), .mispred_cnt_o(mispred_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [31:0] pc, tgt, input logic t, m,
                               input logic [31:0] lk, input logic hit, tk, input logic [31:0] etgt, cnt);
      vec_t x;
      x = '{v, pc, tgt, t, m, lk, hit, tk, etgt, cnt};
      return x;
   endfunction

   task automatic cmp(input string what, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %h, want %h", what, id, act, exp);
      end
   endtask

   task automatic expect_out(input int id, input logic hit, tk, input logic [31:0] tgt, cnt);
      exp_t e;
      e = '{id, hit, tk, tgt, cnt};
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: no expected entry, got hit=%b taken=%b", btb_hit_o, pred_taken_o);
         return;
      end
      e = sb.pop_front();
      cmp("btb_hit", e.id, 32'(btb_hit_o), 32'(e.hit));
      cmp("pred_taken", e.id, 32'(pred_taken_o), 32'(e.tk));
      cmp("pred_target", e.id, pred_target_o, e.tgt);
      cmp("mispred_cnt", e.id, mispred_cnt_o, e.cnt);
   endtask

   task automatic step(input int id, input vec_t x);
      @(posedge clk);
      #1;
      res_valid_i = x.v;
      res_i       = '{pc: x.pc, target: x.tgt, taken: x.t, mispredict: x.m};
      curr_pc_i   = x.lk;
      expect_out(id, x.hit, x.tk, x.etgt, x.cnt);
      @(negedge clk);
      check_out();
   endtask

   initial begin
`ifndef LEN5_BPU_GSHARE_EN
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'd1));
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'd1));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h0,    1'b0, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'd1));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h0,    1'b0, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'd2));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h0,    1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd3));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd4));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd4));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd4));
      vecs.push_back(mk(1'b1, 32'h1040, 32'h3000, 1'b1, 1'b0, 32'h1040, 1'b0, 1'b0, 32'h1044, 32'd4));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h1004, 32'd4));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1040, 1'b1, 1'b1, 32'h3000, 32'd4));
      vecs.push_back(mk(1'b1, 32'h1040, 32'h0,    1'b0, 1'b1, 32'h1040, 1'b1, 1'b1, 32'h3000, 32'd4));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1040, 1'b1, 1'b0, 32'h1044, 32'd5));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h2004, 32'd5));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 32'd5));
`else
      vecs.push_back(mk(1'b1, 32'h1100, 32'h5000, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b1, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h1000, 1'b0, 1'b0, 32'h1004, 32'd0));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1'b1, 32'h1204, 32'h0, 1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b1, 32'h1204, 32'h7000, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 32'h1004, 32'd0));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1000, 1'b1, 1'b1, 32'h2000, 32'd0));
      vecs.push_back(mk(1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 32'h1204, 1'b1, 1'b0, 32'h1208, 32'd0));
`endif
      @(negedge clk);
      expect_out(-1, 1'b0, 1'b0, 32'h1004, 32'd0);
      check_out();
      @(posedge clk);
      #1 rst_i = 1'b0;
      foreach (vecs[i]) step(i, vecs[i]);
`ifndef LEN5_BPU_GSHARE_EN
      @(posedge clk);
      #1;
      res_valid_i = 1'b1;
      res_i       = '{pc: 32'h1040, target: 32'h4000, taken: 1'b1, mispredict: 1'b1};
      curr_pc_i   = 32'h1040;
      #2 rst_i = 1'b1;
      #1;
      expect_out(200, 1'b0, 1'b0, 32'h1044, 32'd0);
      check_out();
      @(posedge clk);
      #1;
      rst_i       = 1'b0;
      res_valid_i = 1'b0;
      expect_out(201, 1'b0, 1'b0, 32'h1044, 32'd0);
      check_out();
      step(202, mk(1'b1, 32'h1040, 32'h4000, 1'b1, 1'b1, 32'h1040, 1'b0, 1'b0, 32'h1044, 32'd0));
      step(203, mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1040, 1'b1, 1'b1, 32'h4000, 32'd1));
`endif
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
